pipe_stall_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 11 +
 rtl/sat_counter.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } ctrl_state_t;

  localparam int CNT_W_DFLT = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: adds one per cycle while inc is high and sticks at all-ones.
// Registered output, async active-low clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller: PC, IF/ID and ID/EX enables/clears, RUN/HALTED FSM, perf counters.
// Controls are combinational on state, inputs and rst_n; counters and halted lag one edge.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             conflict,
  input  logic             ex_redirect,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state_q, state_d;
  logic        resume_q;
  logic        res_edge;
  logic        run_inc, stall_inc, flush_inc;

  assign res_edge = resume & ~resume_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b1;
    if_id_en  = 1'b1;
    if_id_clr = 1'b0;
    id_ex_clr = 1'b0;
    run_inc   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (!rst_n) begin
      // Reset override holds fetch and bubbles both stage registers.
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      if_id_clr = 1'b1;
      id_ex_clr = 1'b1;
    end else if (state_q == HALTED) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_clr = 1'b1;
      if (res_edge) begin
        state_d = RUN;
      end
    end else begin
      run_inc = 1'b1;
      if (halt_req) begin
        state_d   = HALTED;
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_clr = 1'b1;
      end else if (ex_redirect) begin
        // Redirect beats conflict: the stalled instruction is on the wrong path.
        if_id_clr = 1'b1;
        id_ex_clr = 1'b1;
        flush_inc = 1'b1;
      end else if (conflict) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_clr = 1'b1;
        stall_inc = 1'b1;
      end
    end
  end

  assign halted = rst_n & (state_q == HALTED);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_inc),
    .q     (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .q     (flush_cnt)
  );

endmodule
